// File: rtl/switch_debounce_pkg.sv
// Shared constants and helpers for the switch conditioning and counter blocks.
package switch_debounce_pkg;

  // Bits needed to hold the values 0 .. value-1; returns 1 for value <= 2.
  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result = result + 1;
      remain = remain >> 1;
    end
    if (result == 0) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One switch channel: 2-flop synchronizer, stability counter, accepted level
// and registered one-cycle rise/fall pulses.
module debounce_chan
  import switch_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_in,
  output logic sw_out,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             st;
  logic [CNT_W-1:0] cnt;

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("debounce_chan: DEBOUNCE_CYCLES must be at least 2");
  end

  // NOTE: every flop here uses <= so all of them sample the pre-edge values;
  // blocking assignments would let s2 see this edge's s1 and shorten the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      st   <= 1'b0;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= sw_in;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      if (s2 == st) begin
        // Any agreeing cycle throws away a partial count, which rejects bounce.
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        st   <= s2;
        cnt  <= '0;
        rise <= s2;
        fall <= ~s2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign sw_out = st;

endmodule

// File: rtl/switch_debounce.sv
// Synchronises and debounces the board slide switches (bit 0..3 = m, n, u, v)
// and emits per-channel one-cycle rise/fall pulses.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .sw_in (sw_in[i]),
      .sw_out(sw_out[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce with DEBOUNCE_CYCLES=4, WIDTH=4:
// stimulus queues expected pulse events, a negedge monitor pops and compares.
module tb_switch_debounce;

  localparam int WIDTH   = 4;
  localparam int DEB     = 4;
  localparam int LATENCY = DEB + 2;  // negedge drive -> update edge number

  typedef struct {
    int               edge_no;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] val;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] sw_in = '0;
  logic [WIDTH-1:0] sw_out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  switch_debounce #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sw_in (sw_in),
    .sw_out(sw_out),
    .rise  (rise),
    .fall  (fall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expect the currently driven levels on `mask` to be accepted LATENCY edges
  // after this negedge.
  task automatic expect_now(input logic [WIDTH-1:0] mask);
    exp_t e;
    e.edge_no = cyc + LATENCY;
    e.rise    = sw_in & mask;
    e.fall    = ~sw_in & mask;
    e.mask    = mask;
    e.val     = sw_in & mask;
    exp_q.push_back(e);
  endtask

  task automatic toggle(input logic [WIDTH-1:0] mask);
    sw_in = sw_in ^ mask;
    expect_now(mask);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: any pulse must match the oldest queued expectation exactly.
  always @(negedge clk) begin
    if (!rst && (rise != '0 || fall != '0)) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: rise=%b fall=%b at cycle %0d, expected none", rise, fall, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_edge", 32'(cyc), 32'(e.edge_no));
        check("rise", 32'(rise), 32'(e.rise));
        check("fall", 32'(fall), 32'(e.fall));
        check("sw_out_on_pulse", 32'(sw_out & e.mask), 32'(e.val));
      end
    end
  end

  initial begin
    // Power-on reset state
    repeat (2) @(posedge clk);
    #2;
    check("reset_sw_out", 32'(sw_out), 32'h0);
    check("reset_rise", 32'(rise), 32'h0);
    check("reset_fall", 32'(fall), 32'h0);
    @(negedge clk) rst = 1'b0;
    wait_neg(3);

    // All switches up, then asynchronous mid-cycle reset
    toggle(4'b1111);
    wait_neg(8);
    check("all_up_sw_out", 32'(sw_out), 32'hf);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_sw_out", 32'(sw_out), 32'h0);
    check("async_rst_rise", 32'(rise), 32'h0);
    check("async_rst_fall", 32'(fall), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    expect_now(4'b1111);
    wait_neg(8);

    // All released, then clean press on bit 0
    toggle(4'b1111);
    wait_neg(8);
    toggle(4'b0001);
    wait_neg(8);

    // Bounce on bit 1: 3 high, 1 low, then held high
    sw_in[1] = 1'b1;
    wait_neg(3);
    sw_in[1] = 1'b0;
    wait_neg(1);
    sw_in[1] = 1'b1;
    expect_now(4'b0010);
    wait_neg(4);
    check("bounce_no_update", 32'(sw_out[1]), 32'h0);
    wait_neg(4);
    check("bounce_settled", 32'(sw_out), 32'h3);

    // Press then release on bit 2
    toggle(4'b0100);
    wait_neg(8);
    toggle(4'b0100);
    wait_neg(8);
    check("release_sw_out", 32'(sw_out), 32'h3);

    // Independent channels, bits 1 and 3 together
    toggle(4'b0001);
    wait_neg(1);
    toggle(4'b1010);
    wait_neg(2);
    toggle(4'b0100);
    wait_neg(10);
    check("indep_sw_out", 32'(sw_out), 32'hc);

    // Reset after two counted cycles of a bit-0 press
    sw_in[0] = 1'b1;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midcount_rst_sw_out", 32'(sw_out), 32'h0);
    check("midcount_rst_rise", 32'(rise), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    expect_now(sw_in);
    wait_neg(8);
    check("midcount_final_sw_out", 32'(sw_out), 32'hd);

    // Drain with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("pending_expectations", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
